// File: rtl/cam_pkg.sv
// cam_pkg: shared types and geometry constants for the camera readout path
package cam_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FETCH = 2'd2, DONE = 2'd3} state_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int CNT_W        = 10;
endpackage

// File: rtl/sync_toggle_det.sv
// sync_toggle_det: multi-flop synchroniser plus toggle detector, one pulse per input edge
module sync_toggle_det #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_pulse
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  assign o_level = r_sync[STAGES-1];
  assign o_pulse = o_level ^ r_prev;
endmodule

// File: rtl/hps_pixel_bridge.sv
// hps_pixel_bridge: handshaked pixel readout from the SDRAM read FIFO to the HPS PIO pins.
// Each HPS request toggle fetches one FIFO word and is answered with an acknowledge toggle.
module hps_pixel_bridge
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic             iHPS_REQ,
  input  logic [15:0]      iRD_DATA,
  output logic             oRD,
  output logic             oPIX,
  output logic             oACK,
  output logic [CNT_W-1:0] oCOL,
  output logic [CNT_W-1:0] oROW,
  output logic             oFRAME_DONE,
  output logic             oERR,
  output logic [1:0]       oSTATE
);
  state_t           r_state;
  logic             r_rd, r_pix, r_ack, r_done, r_err;
  logic [CNT_W-1:0] r_col, r_row, r_ncol, r_nrow;
  logic [1:0]       r_lat;
  logic             w_start, w_req, w_col_end, w_row_end;
  logic             w_unused_start_edge, w_unused_req_level, w_unused_data;

  sync_toggle_det #(.STAGES(SYNC_STAGES)) u_req (
    .i_clk(iCLK), .i_rst_n(iRST_N), .i_async(iHPS_REQ),
    .o_level(w_unused_req_level), .o_pulse(w_req)
  );
  sync_toggle_det #(.STAGES(SYNC_STAGES)) u_start (
    .i_clk(iCLK), .i_rst_n(iRST_N), .i_async(iSTART),
    .o_level(w_start), .o_pulse(w_unused_start_edge)
  );

  assign w_unused_data = ^iRD_DATA[15:1];
  assign w_col_end     = r_ncol == CNT_W'(H_ACTIVE - 1);
  assign w_row_end     = r_nrow == CNT_W'(V_ACTIVE - 1);

  // oRD defaults low every cycle so it is a single registered pulse and cannot glitch
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_pix   <= 1'b0;
      r_ack   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_ncol  <= '0;
      r_nrow  <= '0;
      r_lat   <= '0;
    end else begin
      r_rd <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= RUN;
          r_col   <= '0;
          r_row   <= '0;
          r_ncol  <= '0;
          r_nrow  <= '0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        RUN: if (!w_start) r_state <= IDLE;
        else if (w_req) begin
          r_rd    <= 1'b1;
          r_lat   <= '0;
          r_state <= FETCH;
        end
        FETCH: if (!w_start) r_state <= IDLE;
        else begin
          if (w_req) r_err <= 1'b1;
          if (r_lat == 2'(RD_LATENCY)) begin
            r_pix   <= iRD_DATA[0];
            r_ack   <= ~r_ack;
            r_col   <= r_ncol;
            r_row   <= r_nrow;
            r_ncol  <= w_col_end ? '0 : r_ncol + 1'b1;
            r_nrow  <= (w_col_end && !w_row_end) ? r_nrow + 1'b1 : r_nrow;
            r_done  <= w_col_end && w_row_end;
            r_state <= (w_col_end && w_row_end) ? DONE : RUN;
          end else r_lat <= r_lat + 1'b1;
        end
        DONE: if (!w_start) r_state <= IDLE;
      endcase
    end

  assign oRD         = r_rd;
  assign oPIX        = r_pix;
  assign oACK        = r_ack;
  assign oCOL        = r_col;
  assign oROW        = r_row;
  assign oFRAME_DONE = r_done;
  assign oERR        = r_err;
  assign oSTATE      = r_state;
endmodule

// File: tb/tb_hps_pixel_bridge.sv
// tb_hps_pixel_bridge: directed vectors for the HPS pixel bridge on a 640x2 frame
module tb_hps_pixel_bridge;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, req = 1'b0;
  logic [15:0] data = '0;
  logic        rd, pix, ack, fdone, err;
  logic [9:0]  col, row;
  logic [1:0]  st;
  int          checks = 0, errors = 0;

  typedef struct {logic d; logic pix; int col; int row;} vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  hps_pixel_bridge #(.H_ACTIVE(640), .V_ACTIVE(2), .SYNC_STAGES(2), .RD_LATENCY(1)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iHPS_REQ(req), .iRD_DATA(data),
    .oRD(rd), .oPIX(pix), .oACK(ack), .oCOL(col), .oROW(row),
    .oFRAME_DONE(fdone), .oERR(err), .oSTATE(st)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    start = v;
    repeat (4) @(negedge clk);
  endtask

  // one request: dbl re-toggles one cycle later, drop (>=0) lowers iSTART at that cycle
  task automatic pixel(input logic d, input bit dbl, input int drop, output int rds, output int acks);
    logic a;
    rds = 0;
    acks = 0;
    a = ack;
    data = {15'd0, d};
    req = ~req;
    if (drop == 0) start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (dbl && i == 0) req = ~req;
      if (i + 1 == drop) start = 1'b0;
      rds += int'(rd);
      if (ack !== a) begin
        acks++;
        a = ack;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_pix"}, pix, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_col"}, col, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_fdone"}, fdone, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_state"}, st, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rds, acks, rd_sum;
    tbl[0] = '{d: 1'b0, pix: 1'b0, col: 1, row: 0};
    tbl[1] = '{d: 1'b1, pix: 1'b1, col: 2, row: 0};
    tbl[2] = '{d: 1'b1, pix: 1'b1, col: 3, row: 0};
    tbl[3] = '{d: 1'b0, pix: 1'b0, col: 4, row: 0};
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    set_start(1'b1);
    chk("start_run", st, 1);
    // first pixel, cycle by cycle
    data = 16'h0001;
    req = ~req;
    @(negedge clk); chk("lat_c1_rd", rd, 0);
    @(negedge clk); chk("lat_c2_rd", rd, 0);
    @(negedge clk); chk("lat_c3_rd", rd, 1); chk("lat_c3_state", st, 2);
    @(negedge clk); chk("lat_c4_rd", rd, 0); chk("lat_c4_ack", ack, 0); chk("lat_c4_state", st, 2);
    @(negedge clk); chk("lat_c5_ack", ack, 1); chk("lat_c5_pix", pix, 1);
    chk("lat_c5_col", col, 0); chk("lat_c5_row", row, 0); chk("lat_c5_state", st, 1);
    repeat (4) @(negedge clk);
    foreach (tbl[k]) begin
      pixel(tbl[k].d, 1'b0, -1, rds, acks);
      chk($sformatf("vec%0d_rd", k), rds, 1);
      chk($sformatf("vec%0d_ack", k), acks, 1);
      chk($sformatf("vec%0d_pix", k), pix, tbl[k].pix);
      chk($sformatf("vec%0d_col", k), col, tbl[k].col);
      chk($sformatf("vec%0d_row", k), row, tbl[k].row);
    end
    for (int n = 5; n < 640; n++) begin
      pixel(n[0], 1'b0, -1, rds, acks);
      chk("alt_pix", pix, n[0]);
    end
    chk("row0_end_col", col, 639);
    chk("row0_end_row", row, 0);
    pixel(1'b1, 1'b0, -1, rds, acks);
    chk("wrap_col", col, 0);
    chk("wrap_row", row, 1);
    // overrun: second request lands while fetching
    pixel(1'b0, 1'b1, -1, rds, acks);
    chk("ovr_rd", rds, 1);
    chk("ovr_ack", acks, 1);
    chk("ovr_err", err, 1);
    chk("ovr_col", col, 1);
    pixel(1'b1, 1'b0, -1, rds, acks);
    chk("ovr_after_col", col, 2);
    chk("ovr_sticky", err, 1);
    for (int n = 643; n < 1279; n++) pixel(n[0], 1'b0, -1, rds, acks);
    chk("pre_last_col", col, 638);
    chk("pre_last_done", fdone, 0);
    pixel(1'b1, 1'b0, -1, rds, acks);
    chk("last_ack", acks, 1);
    chk("last_col", col, 639);
    chk("last_row", row, 1);
    chk("last_done", fdone, 1);
    chk("last_state", st, 3);
    pixel(1'b0, 1'b0, -1, rds, acks);
    chk("done_no_rd", rds, 0);
    chk("done_no_ack", acks, 0);
    chk("done_pix_hold", pix, 1);
    set_start(1'b0);
    chk("stop_state", st, 0);
    chk("stop_err_held", err, 1);
    set_start(1'b1);
    chk("restart_state", st, 1);
    chk("restart_col", col, 0);
    chk("restart_row", row, 0);
    chk("restart_done", fdone, 0);
    chk("restart_err", err, 0);
    // request and abort reach the FSM together: abort wins
    pixel(1'b0, 1'b0, 0, rds, acks);
    chk("sim_abort_rd", rds, 0);
    chk("sim_abort_state", st, 0);
    set_start(1'b1);
    // abort arrives the cycle after oRD: latch dropped
    pixel(1'b0, 1'b0, 1, rds, acks);
    chk("abort_rd", rds, 1);
    chk("abort_ack", acks, 0);
    chk("abort_state", st, 0);
    chk("abort_pix_hold", pix, 1);
    set_start(1'b1);
    pixel(1'b0, 1'b0, -1, rds, acks);
    chk("resume_ack", acks, 1);
    chk("resume_pix", pix, 0);
    chk("resume_col", col, 0);
    chk("resume_row", row, 0);
    pixel(1'b1, 1'b0, -1, rds, acks);
    chk("resume2_col", col, 1);
    // async reset while in FETCH
    data = 16'h0001;
    req = ~req;
    repeat (4) @(negedge clk);
    chk("pre_rst_state", st, 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    rd_sum = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd_sum += int'(rd);
    end
    chk("post_rst_no_rd", rd_sum, 0);
    chk("post_rst_ack", ack, 0);
    chk("post_rst_state", st, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
